// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operation sequencer: FSM encoding,
// instruction/issue structs and the operand-B select helper.
package alu_pkg;

  localparam int DATA_W   = 8;
  localparam int ALU_OP_W = 3;
  localparam int NREG     = 4;
  localparam int REG_AW   = 2;
  localparam int CNT_W    = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_WB    = 2'd3;

  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic                cin;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   ra;
    logic [REG_AW-1:0]   rb;
    logic                imm_en;
    logic [DATA_W-1:0]   imm;
  } instr_t;

  // Operand snapshot taken at accept; immune to later host writes.
  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic                cin;
    logic [REG_AW-1:0]   rd;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
  } issue_t;

  function automatic logic [DATA_W-1:0] sel_operand_b(
    input logic              imm_en,
    input logic [DATA_W-1:0] imm,
    input logic [DATA_W-1:0] reg_b
  );
    logic [DATA_W-1:0] b;
    if (imm_en) begin
      b = imm;
    end else begin
      b = reg_b;
    end
    return b;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4 x 8-bit register file: one synchronous write per register per edge where
// writeback beats the host load, two operand read ports and an observation port.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              host_en,
  input  logic [REG_AW-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [REG_AW-1:0] obs_addr,
  output logic [DATA_W-1:0] obs_data
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  // Next register contents; writeback has priority on a same-register collision.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (wb_en && (wb_addr == REG_AW'(i))) begin
        regs_d[i] = wb_data;
      end else if (host_en && (host_addr == REG_AW'(i))) begin
        regs_d[i] = host_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign obs_data = regs_q[obs_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one instruction at a time to an external registered ALU, waits out its
// latency, then writes the result back to the register file and the carry flag.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [ALU_OP_W-1:0] instr_op,
  input  logic                instr_cin,
  input  logic [REG_AW-1:0]   instr_rd,
  input  logic [REG_AW-1:0]   instr_ra,
  input  logic [REG_AW-1:0]   instr_rb,
  input  logic                instr_imm_en,
  input  logic [DATA_W-1:0]   instr_imm,
  input  logic                wr_en,
  input  logic [REG_AW-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [REG_AW-1:0]   obs_addr,
  output logic [DATA_W-1:0]   obs_data,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic                alu_cin,
  output logic [ALU_OP_W-1:0] alu_s,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                alu_cout,
  output logic                carry,
  output logic                done,
  output logic [DATA_W-1:0]   result
);

  localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  instr_t              instr_s;
  issue_t              iss_q, iss_d;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic                alu_cin_q, alu_cin_d;
  logic [ALU_OP_W-1:0] alu_s_q, alu_s_d;
  logic                carry_q, carry_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   rf_a_s, rf_b_s;
  logic                wb_en_s;

  assign instr_s = '{op: instr_op, cin: instr_cin, rd: instr_rd, ra: instr_ra,
                     rb: instr_rb, imm_en: instr_imm_en, imm: instr_imm};
  assign wb_en_s = (state_q == ST_WB);

  alu_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_en     (wb_en_s),
    .wb_addr   (iss_q.rd),
    .wb_data   (alu_data),
    .host_en   (wr_en),
    .host_addr (wr_addr),
    .host_data (wr_data),
    .ra_addr   (instr_s.ra),
    .ra_data   (rf_a_s),
    .rb_addr   (instr_s.rb),
    .rb_data   (rf_b_s),
    .obs_addr  (obs_addr),
    .obs_data  (obs_data)
  );

  // FSM next-state, operand snapshot, ALU drive and writeback.
  always_comb begin
    state_d   = state_q;
    iss_d     = iss_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_cin_d = alu_cin_q;
    alu_s_d   = alu_s_q;
    carry_d   = carry_q;
    result_d  = result_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          iss_d.op  = instr_s.op;
          iss_d.cin = instr_s.cin;
          iss_d.rd  = instr_s.rd;
          iss_d.a   = rf_a_s;
          iss_d.b   = sel_operand_b(instr_s.imm_en, instr_s.imm, rf_b_s);
          state_d   = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        alu_a_d   = iss_q.a;
        alu_b_d   = iss_q.b;
        alu_cin_d = iss_q.cin;
        alu_s_d   = iss_q.op;
        cnt_d     = LAT_M1;
        state_d   = ST_WAIT;
      end
      // One WAIT cycle per ALU latency clock, so data is settled before WB samples it.
      ST_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_WB;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_WB: begin
        result_d = alu_data;
        if (!iss_q.op[2]) begin
          carry_d = alu_cout;
        end else begin
          carry_d = carry_q;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      iss_q     <= '0;
      cnt_q     <= {CNT_W{1'b0}};
      alu_a_q   <= {DATA_W{1'b0}};
      alu_b_q   <= {DATA_W{1'b0}};
      alu_cin_q <= 1'b0;
      alu_s_q   <= {ALU_OP_W{1'b0}};
      carry_q   <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= {DATA_W{1'b0}};
    end else begin
      state_q   <= state_d;
      iss_q     <= iss_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_cin_q <= alu_cin_d;
      alu_s_q   <= alu_s_d;
      carry_q   <= carry_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_cin     = alu_cin_q;
  assign alu_s       = alu_s_q;
  assign carry       = carry_q;
  assign done        = done_q;
  assign result      = result_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: one sequencer with ALU_LAT=1 and one with ALU_LAT=3, each
// attached to a behavioural registered ALU (000: A+B+Cin, 100: A&B).
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] instr_op = 3'd0;
  logic       instr_cin = 1'b0;
  logic [1:0] instr_rd = 2'd0, instr_ra = 2'd0, instr_rb = 2'd0;
  logic       instr_imm_en = 1'b0;
  logic [7:0] instr_imm = 8'd0;
  logic       valid1 = 1'b0, valid3 = 1'b0;
  logic       wr_en1 = 1'b0, wr_en3 = 1'b0;
  logic [1:0] wr_addr = 2'd0, obs_addr = 2'd0;
  logic [7:0] wr_data = 8'd0;

  logic       ready1, ready3, cin1, cin3, carry1, carry3, done1, done3;
  logic [7:0] obs1, obs3, a1, a3, b1, b3, result1, result3;
  logic [2:0] s1, s3;
  logic [8:0] alu1_q, alu3_p0, alu3_p1, alu3_p2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic [2:0] s);
    case (s)
      3'b000:  alu_f = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      3'b100:  alu_f = {1'b0, a & b};
      default: alu_f = {1'b0, a ^ b};
    endcase
  endfunction

  always @(posedge clk) begin
    alu1_q  <= alu_f(a1, b1, cin1, s1);
    alu3_p0 <= alu_f(a3, b3, cin3, s3);
    alu3_p1 <= alu3_p0;
    alu3_p2 <= alu3_p1;
  end

  alu_op_sequencer #(.ALU_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(valid1), .instr_ready(ready1),
    .instr_op(instr_op), .instr_cin(instr_cin), .instr_rd(instr_rd),
    .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_imm_en(instr_imm_en),
    .instr_imm(instr_imm), .wr_en(wr_en1), .wr_addr(wr_addr), .wr_data(wr_data),
    .obs_addr(obs_addr), .obs_data(obs1), .alu_a(a1), .alu_b(b1), .alu_cin(cin1),
    .alu_s(s1), .alu_data(alu1_q[7:0]), .alu_cout(alu1_q[8]), .carry(carry1),
    .done(done1), .result(result1)
  );

  alu_op_sequencer #(.ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .instr_valid(valid3), .instr_ready(ready3),
    .instr_op(instr_op), .instr_cin(instr_cin), .instr_rd(instr_rd),
    .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_imm_en(instr_imm_en),
    .instr_imm(instr_imm), .wr_en(wr_en3), .wr_addr(wr_addr), .wr_data(wr_data),
    .obs_addr(obs_addr), .obs_data(obs3), .alu_a(a3), .alu_b(b3), .alu_cin(cin3),
    .alu_s(s3), .alu_data(alu3_p2[7:0]), .alu_cout(alu3_p2[8]), .carry(carry3),
    .done(done3), .result(result3)
  );

  task automatic set_instr(input logic [2:0] op, input logic cin, input logic [1:0] rd,
                           input logic [1:0] ra, input logic [1:0] rb,
                           input logic imm_en, input logic [7:0] imm);
    instr_op = op; instr_cin = cin; instr_rd = rd; instr_ra = ra;
    instr_rb = rb; instr_imm_en = imm_en; instr_imm = imm;
  endtask

  // Offer for one edge; returns at the negedge after the accept edge.
  task automatic issue1(input logic [2:0] op, input logic cin, input logic [1:0] rd,
                        input logic [1:0] ra, input logic [1:0] rb,
                        input logic imm_en, input logic [7:0] imm);
    set_instr(op, cin, rd, ra, rb, imm_en, imm);
    valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    set_instr(3'd7, 1'b1, 2'd3, 2'd3, 2'd3, 1'b1, 8'hEE);
  endtask

  task automatic host_wr(input bit which3, input logic [1:0] addr, input logic [7:0] data);
    wr_addr = addr; wr_data = data;
    if (which3) wr_en3 = 1'b1; else wr_en1 = 1'b1;
    @(negedge clk);
    wr_en1 = 1'b0; wr_en3 = 1'b0;
  endtask

  task automatic rd_reg(input bit which3, input logic [1:0] addr, output logic [7:0] data);
    obs_addr = addr;
    #1;
    data = which3 ? obs3 : obs1;
  endtask

  task automatic wait_done1(input int start, output int cyc);
    cyc = start;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done1) break;
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    repeat (2) @(negedge clk);
    rd_reg(1'b0, 2'd0, v);
    checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0h exp=1", ready1); end
    checks++; if ({done1, carry1, result1} !== 10'h000) begin failures++; $display("FAIL reset_outs got=%0h exp=0", {done1, carry1, result1}); end
    checks++; if ({a1, b1, cin1, s1} !== 20'h00000) begin failures++; $display("FAIL reset_alu got=%0h exp=0", {a1, b1, cin1, s1}); end
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_r0 got=%0h exp=0", v); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_carry();
    int cyc; logic [7:0] v;
    host_wr(1'b0, 2'd1, 8'hFF);
    host_wr(1'b0, 2'd2, 8'h01);
    issue1(3'b000, 1'b0, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00);
    wait_done1(0, cyc);
    rd_reg(1'b0, 2'd3, v);
    checks++; if (cyc !== 3) begin failures++; $display("FAIL add_latency got=%0d exp=3", cyc); end
    checks++; if (result1 !== 8'h00) begin failures++; $display("FAIL add_result got=%0h exp=00", result1); end
    checks++; if (carry1 !== 1'b1) begin failures++; $display("FAIL add_carry got=%0h exp=1", carry1); end
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL add_r3 got=%0h exp=00", v); end
    @(negedge clk);
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL done_pulse got=%0h exp=0", done1); end
  endtask

  task automatic test_logic_imm();
    int cyc; logic [7:0] v;
    host_wr(1'b0, 2'd0, 8'hF0);
    issue1(3'b100, 1'b0, 2'd0, 2'd0, 2'd1, 1'b1, 8'h3C);
    wait_done1(0, cyc);
    rd_reg(1'b0, 2'd0, v);
    checks++; if (cyc !== 3) begin failures++; $display("FAIL and_latency got=%0d exp=3", cyc); end
    checks++; if (v !== 8'h30) begin failures++; $display("FAIL and_r0 got=%0h exp=30", v); end
    checks++; if (result1 !== 8'h30) begin failures++; $display("FAIL and_result got=%0h exp=30", result1); end
    checks++; if (carry1 !== 1'b1) begin failures++; $display("FAIL and_carry_kept got=%0h exp=1", carry1); end
  endtask

  task automatic test_snapshot();
    int cyc; logic [7:0] v, w;
    issue1(3'b000, 1'b1, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01);
    @(negedge clk);
    host_wr(1'b0, 2'd1, 8'h55);
    wait_done1(2, cyc);
    rd_reg(1'b0, 2'd1, v);
    rd_reg(1'b0, 2'd2, w);
    checks++; if (result1 !== 8'h01) begin failures++; $display("FAIL snap_result got=%0h exp=01", result1); end
    checks++; if (v !== 8'h55) begin failures++; $display("FAIL snap_r1 got=%0h exp=55", v); end
    checks++; if (w !== 8'h01) begin failures++; $display("FAIL snap_r2 got=%0h exp=01", w); end
    checks++; if (carry1 !== 1'b1) begin failures++; $display("FAIL snap_carry got=%0h exp=1", carry1); end
  endtask

  task automatic test_wb_collision();
    logic [7:0] v, w;
    issue1(3'b000, 1'b1, 2'd1, 2'd1, 2'd2, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    host_wr(1'b0, 2'd1, 8'hAA);
    rd_reg(1'b0, 2'd1, v);
    checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL coll_done got=%0h exp=1", done1); end
    checks++; if (v !== 8'h57) begin failures++; $display("FAIL coll_r1 got=%0h exp=57", v); end
    checks++; if (carry1 !== 1'b0) begin failures++; $display("FAIL coll_carry got=%0h exp=0", carry1); end
    issue1(3'b100, 1'b0, 2'd3, 2'd1, 2'd0, 1'b1, 8'h0F);
    repeat (2) @(negedge clk);
    host_wr(1'b0, 2'd0, 8'h77);
    rd_reg(1'b0, 2'd3, v);
    rd_reg(1'b0, 2'd0, w);
    checks++; if (v !== 8'h07) begin failures++; $display("FAIL other_r3 got=%0h exp=07", v); end
    checks++; if (w !== 8'h77) begin failures++; $display("FAIL other_r0 got=%0h exp=77", w); end
    checks++; if (carry1 !== 1'b0) begin failures++; $display("FAIL other_carry got=%0h exp=0", carry1); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    host_wr(1'b1, 2'd0, 8'h10);
    host_wr(1'b1, 2'd1, 8'h20);
    checks++; if (ready3 !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%0h exp=1", ready3); end
    set_instr(3'b000, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, 8'h00);
    valid3 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 7) valid3 = 1'b0;
      checks++;
      if (ready3 !== ((k % 6) == 0) || done3 !== ((k % 6) == 0)) begin
        failures++;
        $display("FAIL b2b_hs k=%0d got ready=%0h done=%0h exp=%0h", k, ready3, done3, (k % 6) == 0);
      end
      if ((k >= 2 && k <= 5) || (k >= 8 && k <= 11)) begin
        checks++;
        if (a3 !== ((k < 6) ? 8'h10 : 8'h30) || b3 !== 8'h20 || s3 !== 3'b000) begin
          failures++;
          $display("FAIL b2b_alu k=%0d got a=%0h b=%0h s=%0h", k, a3, b3, s3);
        end
      end
      if (k == 6) begin
        checks++; if (result3 !== 8'h30) begin failures++; $display("FAIL b2b_res1 got=%0h exp=30", result3); end
      end
    end
    rd_reg(1'b1, 2'd0, v);
    checks++; if (result3 !== 8'h50) begin failures++; $display("FAIL b2b_res2 got=%0h exp=50", result3); end
    checks++; if (v !== 8'h50) begin failures++; $display("FAIL b2b_r0 got=%0h exp=50", v); end
  endtask

  task automatic test_reset_midop();
    logic [7:0] v;
    bit seen_done;
    set_instr(3'b000, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h00);
    valid3 = 1'b1;
    @(negedge clk);
    valid3 = 1'b0;
    @(negedge clk);
    checks++; if (ready3 !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0h exp=0", ready3); end
    rst_n = 1'b0;
    #1;
    checks++; if (ready3 !== 1'b1) begin failures++; $display("FAIL mid_ready got=%0h exp=1", ready3); end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done3 || !ready3) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL mid_no_wb got=%0h exp=0", seen_done); end
    for (int r = 0; r < 4; r++) begin
      rd_reg(1'b1, 2'(r), v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL mid_reg%0d got=%0h exp=00", r, v); end
    end
    checks++; if ({carry3, result3, a3} !== 17'h00000) begin failures++; $display("FAIL mid_state got=%0h exp=0", {carry3, result3, a3}); end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_logic_imm();
    test_snapshot();
    test_wb_collision();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
